// File: rtl/safety_pkg.sv
// Shared types and constants for the keypad lock controller.
package safety_pkg;

  localparam int DIGIT_W  = 4;
  localparam int NUM_KEYS = 10;

  typedef enum logic [1:0] {
    S_ENTRY   = 2'd0,
    S_OPEN    = 2'd1,
    S_SET     = 2'd2,
    S_LOCKOUT = 2'd3
  } lock_state_t;

  // Index of the highest set key; only meaningful when exactly one bit is set.
  function automatic logic [DIGIT_W-1:0] key_encode(input logic [NUM_KEYS-1:0] keys);
    key_encode = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys[i]) key_encode = DIGIT_W'(i);
    end
  endfunction

endpackage

// File: rtl/lock_controller_rise_detect.sv
// Rising-edge detector with registered history. History resets to ones so
// inputs already high when reset releases produce no event.
module rise_detect #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) hist <= '1;
    else     hist <= din;
  end

  assign rise = din & ~hist;

endmodule

// File: rtl/lock_controller.sv
// Keypad passcode lock: entry, timed open, passcode change and failure lockout.
//
// state     | meaning
// ----------|------------------------------------------------------------
// S_ENTRY   | collecting passcode digits, ENTER compares against code
// S_OPEN    | unlocked, shared timer counts down to automatic relock
// S_SET     | collecting a new passcode, ENTER stores it if complete
// S_LOCKOUT | too many failures, keys ignored until shared timer expires
module lock_controller
  import safety_pkg::*;
#(
  parameter int          DIGITS       = 4,
  parameter int          MAX_FAIL     = 3,
  parameter int          OPEN_CYC     = 1000,
  parameter int          LOCK_CYC     = 5000,
  parameter logic [31:0] DEFAULT_CODE = 32'h0000_1234
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_KEYS-1:0]               key_dbn,
  input  logic                              enter_dbn,
  input  logic                              clear_dbn,
  output logic                              unlocked,
  output logic                              alarm,
  output logic                              set_mode,
  output logic [3:0]                        digit_cnt,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int TMAX   = (OPEN_CYC > LOCK_CYC) ? OPEN_CYC : LOCK_CYC;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [3:0]        DIGITS_L  = 4'(DIGITS);
  localparam logic [TW-1:0]     OPEN_LOAD = TW'(OPEN_CYC - 1);
  localparam logic [TW-1:0]     LOCK_LOAD = TW'(LOCK_CYC - 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);

  logic [NUM_KEYS+1:0] rise;
  logic [NUM_KEYS-1:0] key_rise;
  logic                enter_ev, clear_ev, digit_ev;
  logic [DIGIT_W-1:0]  digit_val;

  rise_detect #(.WIDTH(NUM_KEYS + 2)) u_rise (
    .clk  (clk),
    .rst  (rst),
    .din  ({clear_dbn, enter_dbn, key_dbn}),
    .rise (rise)
  );

  assign key_rise  = rise[NUM_KEYS-1:0];
  assign enter_ev  = rise[NUM_KEYS];
  assign clear_ev  = rise[NUM_KEYS+1];
  assign digit_ev  = $onehot(key_rise);
  assign digit_val = key_encode(key_rise);

  lock_state_t         state, state_nx;
  logic [CODE_W-1:0]   entry_buf, buf_nx;
  logic [CODE_W-1:0]   code, code_nx;
  logic [3:0]          cnt_nx;
  logic                ovf, ovf_nx;
  logic [FAIL_W-1:0]   fail_nx;
  logic [TW-1:0]       timer, timer_nx;
  logic                match;

  assign match = (digit_cnt == DIGITS_L) && !ovf && (entry_buf == code);

  always_comb begin
    state_nx = state;
    buf_nx   = entry_buf;
    code_nx  = code;
    cnt_nx   = digit_cnt;
    ovf_nx   = ovf;
    fail_nx  = fail_cnt;
    timer_nx = timer;

    // Digit collection shared by ENTRY and SET; the first digit typed ends up
    // most significant so a code reads in typed order.
    if ((state == S_ENTRY || state == S_SET) && digit_ev) begin
      if (digit_cnt == DIGITS_L) begin
        ovf_nx = 1'b1;
      end else begin
        buf_nx = CODE_W'({entry_buf, digit_val});
        cnt_nx = digit_cnt + 4'd1;
      end
    end

    unique case (state)
      S_ENTRY: begin
        if (enter_ev) begin
          buf_nx = '0;
          cnt_nx = '0;
          ovf_nx = 1'b0;
          if (match) begin
            state_nx = S_OPEN;
            fail_nx  = '0;
            timer_nx = OPEN_LOAD;
          end else if (fail_cnt == FAIL_LAST) begin
            state_nx = S_LOCKOUT;
            fail_nx  = FAIL_MAX;
            timer_nx = LOCK_LOAD;
          end else begin
            fail_nx = fail_cnt + 1'b1;
          end
        end else if (clear_ev) begin
          buf_nx = '0;
          cnt_nx = '0;
          ovf_nx = 1'b0;
        end
      end
      S_OPEN: begin
        buf_nx = '0;
        cnt_nx = '0;
        ovf_nx = 1'b0;
        if (enter_ev || timer == '0) begin
          state_nx = S_ENTRY;
          timer_nx = '0;
        end else if (clear_ev) begin
          state_nx = S_SET;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      S_SET: begin
        if (enter_ev || clear_ev) begin
          if (enter_ev && digit_cnt == DIGITS_L && !ovf) code_nx = entry_buf;
          state_nx = S_OPEN;
          timer_nx = OPEN_LOAD;
          buf_nx   = '0;
          cnt_nx   = '0;
          ovf_nx   = 1'b0;
        end
      end
      S_LOCKOUT: begin
        if (timer == '0) begin
          state_nx = S_ENTRY;
          fail_nx  = '0;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ENTRY;
      entry_buf <= '0;
      code      <= DEFAULT_CODE[CODE_W-1:0];
      digit_cnt <= '0;
      ovf       <= 1'b0;
      fail_cnt  <= '0;
      timer     <= '0;
      unlocked  <= 1'b0;
      alarm     <= 1'b0;
      set_mode  <= 1'b0;
    end else begin
      state     <= state_nx;
      entry_buf <= buf_nx;
      code      <= code_nx;
      digit_cnt <= cnt_nx;
      ovf       <= ovf_nx;
      fail_cnt  <= fail_nx;
      timer     <= timer_nx;
      unlocked  <= (state_nx == S_OPEN);
      alarm     <= (state_nx == S_LOCKOUT);
      set_mode  <= (state_nx == S_SET);
    end
  end

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller with a queue of expected output values.
module tb_lock_controller;

  localparam int OC = 16;
  localparam int LC = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] key_dbn = '0;
  logic       enter_dbn = 1'b0;
  logic       clear_dbn = 1'b0;
  logic       unlocked, alarm, set_mode;
  logic [3:0] digit_cnt;
  logic [1:0] fail_cnt;

  int errors = 0;
  int checks = 0;

  typedef enum int {O_UNL, O_ALM, O_SET, O_CNT, O_FAIL} sig_t;
  typedef struct {
    string       tag;
    sig_t        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  lock_controller #(
    .DIGITS(4), .MAX_FAIL(3), .OPEN_CYC(OC), .LOCK_CYC(LC),
    .DEFAULT_CODE(32'h0000_1234)
  ) dut (
    .clk(clk), .rst(rst), .key_dbn(key_dbn), .enter_dbn(enter_dbn),
    .clear_dbn(clear_dbn), .unlocked(unlocked), .alarm(alarm),
    .set_mode(set_mode), .digit_cnt(digit_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input sig_t s);
    case (s)
      O_UNL:   observe = {31'b0, unlocked};
      O_ALM:   observe = {31'b0, alarm};
      O_SET:   observe = {31'b0, set_mode};
      O_CNT:   observe = {28'b0, digit_cnt};
      default: observe = {30'b0, fail_cnt};
    endcase
  endfunction

  task automatic push(input string tag, input sig_t s, input int v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      checks++;
      assert (obs === e.exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic [9:0] k, input logic ent, input logic clr);
    key_dbn   = k;
    enter_dbn = ent;
    clear_dbn = clr;
  endtask

  task automatic idle(input int n);
    drive('0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Expectations pushed before these tasks are checked at the event edge.
  task automatic key(input int d);
    logic [9:0] k;
    k = '0;
    k[d] = 1'b1;
    drive(k, 1'b0, 1'b0);
    tick();
    idle(1);
  endtask

  task automatic enter();
    drive('0, 1'b1, 1'b0);
    tick();
    idle(1);
  endtask

  task automatic clear();
    drive('0, 1'b0, 1'b1);
    tick();
    idle(1);
  endtask

  task automatic type4(input int a, input int b, input int c, input int d);
    push("cnt1", O_CNT, 1); key(a);
    push("cnt2", O_CNT, 2); key(b);
    push("cnt3", O_CNT, 3); key(c);
    push("cnt4", O_CNT, 4); key(d);
  endtask

  initial begin
    // reset with key 5 held through release
    drive(10'b00_0010_0000, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    push("rst_unl", O_UNL, 0);
    push("rst_alm", O_ALM, 0);
    push("rst_set", O_SET, 0);
    push("rst_cnt", O_CNT, 0);
    push("rst_fail", O_FAIL, 0);
    tick();
    rst = 1'b0;
    push("held_key_no_event", O_CNT, 0);
    tick();
    idle(2);

    // correct code opens for exactly OC cycles
    type4(1, 2, 3, 4);
    push("open_unl", O_UNL, 1);
    push("open_fail", O_FAIL, 0);
    push("open_cnt", O_CNT, 0);
    enter();
    idle(OC - 3);
    push("open_last", O_UNL, 1);
    tick();
    push("open_expire", O_UNL, 0);
    tick();
    idle(2);

    // three wrong entries lead to lockout
    type4(1, 2, 3, 5);
    push("fail1", O_FAIL, 1);
    push("fail1_unl", O_UNL, 0);
    enter();
    type4(1, 2, 3, 5);
    push("fail2", O_FAIL, 2);
    enter();
    type4(1, 2, 3, 5);
    push("lock_alm", O_ALM, 1);
    push("lock_fail", O_FAIL, 3);
    enter();
    push("lock_key_ignored", O_CNT, 0);
    push("lock_alm_hold", O_ALM, 1);
    key(7);
    idle(LC - 5);
    push("lock_last", O_ALM, 1);
    tick();
    push("lock_expire", O_ALM, 0);
    push("lock_fail_clr", O_FAIL, 0);
    tick();
    idle(2);

    // overflow entry fails
    type4(1, 2, 3, 4);
    push("ovf_cnt", O_CNT, 4);
    key(4);
    push("ovf_unl", O_UNL, 0);
    push("ovf_fail", O_FAIL, 1);
    enter();

    // held key counts once
    drive(10'b00_0000_0010, 1'b0, 1'b0);
    push("hold_first", O_CNT, 1);
    tick();
    for (int i = 0; i < 38; i++) tick();
    push("hold_end", O_CNT, 1);
    tick();
    push("clear_cnt", O_CNT, 0);
    push("clear_fail", O_FAIL, 1);
    clear();

    // simultaneous digit rises are ignored
    drive(10'b00_0010_1000, 1'b0, 1'b0);
    push("two_keys", O_CNT, 0);
    tick();
    idle(1);

    // change code to 9876
    type4(1, 2, 3, 4);
    push("set_open", O_UNL, 1);
    push("set_open_fail", O_FAIL, 0);
    enter();
    push("set_mode_on", O_SET, 1);
    push("set_unl_off", O_UNL, 0);
    clear();
    type4(9, 8, 7, 6);
    push("set_mode_off", O_SET, 0);
    push("set_stored_unl", O_UNL, 1);
    enter();
    push("relock", O_UNL, 0);
    enter();
    type4(9, 8, 7, 6);
    push("new_code_unl", O_UNL, 1);
    enter();
    push("relock2", O_UNL, 0);
    enter();
    type4(1, 2, 3, 4);
    push("old_code_unl", O_UNL, 0);
    push("old_code_fail", O_FAIL, 1);
    enter();

    // ENTER with a digit applies ENTER only
    push("c1", O_CNT, 1); key(9);
    push("c2", O_CNT, 2); key(8);
    push("c3", O_CNT, 3); key(7);
    drive(10'b00_0100_0000, 1'b1, 1'b0);
    push("ent_dig_unl", O_UNL, 0);
    push("ent_dig_fail", O_FAIL, 2);
    push("ent_dig_cnt", O_CNT, 0);
    tick();
    idle(1);

    // ENTER with CLEAR in OPEN relocks rather than entering SET
    type4(9, 8, 7, 6);
    push("reopen", O_UNL, 1);
    push("reopen_fail", O_FAIL, 0);
    enter();
    drive('0, 1'b1, 1'b1);
    push("ent_clr_unl", O_UNL, 0);
    push("ent_clr_set", O_SET, 0);
    tick();
    idle(1);

    // reset in SET restores default code
    type4(9, 8, 7, 6);
    enter();
    push("set2_on", O_SET, 1);
    clear();
    push("set2_c1", O_CNT, 1); key(1);
    drive(10'b00_0010_0000, 1'b0, 1'b0);
    rst = 1'b1;
    push("rst_set_off", O_SET, 0);
    push("rst_set_cnt", O_CNT, 0);
    push("rst_set_unl", O_UNL, 0);
    tick();
    rst = 1'b0;
    idle(2);
    type4(9, 8, 7, 6);
    push("post_rst_9876", O_UNL, 0);
    push("post_rst_fail", O_FAIL, 1);
    enter();
    type4(1, 2, 3, 4);
    push("post_rst_1234", O_UNL, 1);
    enter();
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
